// File: rtl/ransac_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the
// Nios II data master (A) and the RANSAC burst-read fetch engine (B).
module ransac_mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  a_address,
    input  logic [BE_W-1:0]    a_byteenable,
    input  logic               a_read,
    input  logic               a_write,
    input  logic [DATA_W-1:0]  a_writedata,
    output logic               a_waitrequest,
    output logic [DATA_W-1:0]  a_readdata,
    output logic               a_readdatavalid,
    input  logic [ADDR_W-1:0]  b_address,
    input  logic [BE_W-1:0]    b_byteenable,
    input  logic               b_read,
    input  logic               b_write,
    input  logic [DATA_W-1:0]  b_writedata,
    input  logic [BURST_W-1:0] b_burstcount,
    output logic               b_waitrequest,
    output logic [DATA_W-1:0]  b_readdata,
    output logic               b_readdatavalid,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic               mem_clken,
    input  logic [DATA_W-1:0]  mem_readdata
);

    typedef enum logic {ARB, BURST} state_t;

    state_t             state, state_nx;
    logic               rr_last, rr_nx;
    logic [BURST_W-1:0] cnt, cnt_nx;
    logic [ADDR_W-1:0]  baddr, baddr_nx;
    logic [BE_W-1:0]    bbe, bbe_nx;
    logic               tag_a, tag_b;
    logic               rd_a, rd_b;
    logic               req_a, req_b;
    logic               grant_a, grant_b;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    assign a_waitrequest   = req_a & ~grant_a;
    assign b_waitrequest   = req_b & ~grant_b;
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;
    assign a_readdatavalid = tag_a;
    assign b_readdatavalid = tag_b;
    assign mem_clken       = 1'b1;

    // rr_last = 1 means B was granted last; grants are held off during reset
    always_comb begin
        state_nx       = state;
        rr_nx          = rr_last;
        cnt_nx         = cnt;
        baddr_nx       = baddr;
        bbe_nx         = bbe;
        grant_a        = 1'b0;
        grant_b        = 1'b0;
        rd_a           = 1'b0;
        rd_b           = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (reset_n) begin
            unique case (state)
                ARB: begin
                    grant_a = req_a & (~req_b | rr_last);
                    grant_b = req_b & ~grant_a;
                    if (grant_a) begin
                        mem_address    = a_address;
                        mem_byteenable = a_byteenable;
                        mem_chipselect = 1'b1;
                        mem_write      = a_write;
                        mem_writedata  = a_writedata;
                        rd_a           = ~a_write;
                        rr_nx          = 1'b0;
                    end else if (grant_b) begin
                        mem_address    = b_address;
                        mem_byteenable = b_byteenable;
                        mem_chipselect = 1'b1;
                        mem_write      = b_write;
                        mem_writedata  = b_writedata;
                        rd_b           = ~b_write;
                        rr_nx          = 1'b1;
                        if (~b_write && b_burstcount > BURST_W'(1)) begin
                            state_nx = BURST;
                            cnt_nx   = b_burstcount - BURST_W'(1);
                            baddr_nx = b_address + ADDR_W'(1);
                            bbe_nx   = b_byteenable;
                        end
                    end
                end
                BURST: begin
                    mem_address    = baddr;
                    mem_byteenable = bbe;
                    mem_chipselect = 1'b1;
                    rd_b           = 1'b1;
                    baddr_nx       = baddr + ADDR_W'(1);
                    cnt_nx         = cnt - BURST_W'(1);
                    if (cnt == BURST_W'(1)) begin
                        state_nx = ARB;
                        rr_nx    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB;
            rr_last <= 1'b1;
            cnt     <= '0;
            baddr   <= '0;
            bbe     <= '0;
            tag_a   <= 1'b0;
            tag_b   <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_last <= rr_nx;
            cnt     <= cnt_nx;
            baddr   <= baddr_nx;
            bbe     <= bbe_nx;
            tag_a   <= rd_a;
            tag_b   <= rd_b;
        end
    end

endmodule

// File: tb/tb_ransac_mem_arbiter.sv
// Bench for ransac_mem_arbiter: directed cases plus random traffic
// checked against a transaction-level shared-memory model.
module tb_ransac_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] a_address, b_address;
    logic [3:0]  a_byteenable, b_byteenable;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_writedata, b_writedata;
    logic [4:0]  b_burstcount;
    logic        a_waitrequest, b_waitrequest;
    logic [31:0] a_readdata, b_readdata;
    logic        a_readdatavalid, b_readdatavalid;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    ransac_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_byteenable(a_byteenable),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_burstcount(b_burstcount), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM: registered address, q valid the cycle after a read
    logic [31:0] ram [0:16383];
    logic [31:0] q;
    assign mem_readdata = q;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i])
                        ram[mem_address][8*i +: 8] = mem_writedata[8*i +: 8];
            end else begin
                q <= ram[mem_address];
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0] shadow [0:16383];
    int          left;
    logic [13:0] m_baddr;
    logic [3:0]  m_bbe;
    bit          last_b;
    bit          va, vb;
    logic [31:0] da, db;
    bit          a_acc, b_acc;

    task automatic model_reset();
        left = 0; last_b = 1; va = 0; vb = 0; m_baddr = '0; m_bbe = '0;
    endtask

    task automatic shadow_write(input logic [13:0] ad, input logic [3:0] be,
                                input logic [31:0] wd);
        for (int i = 0; i < 4; i++)
            if (be[i]) shadow[ad][8*i +: 8] = wd[8*i +: 8];
    endtask

    // called at a negedge with inputs set; returns at the next negedge
    task automatic step();
        bit ra, rb, ga, gb, burst, nva, nvb;
        logic [31:0] nda, ndb;
        int k;
        #1;
        nva = 0; nvb = 0; nda = '0; ndb = '0;
        check("a_rdv", a_readdatavalid, va);
        check("b_rdv", b_readdatavalid, vb);
        if (va) check("a_rdata", a_readdata, da);
        if (vb) check("b_rdata", b_readdata, db);
        check("clken", mem_clken, 1);
        ra = a_read | a_write;
        rb = b_read | b_write;
        burst = left > 0;
        ga = 0; gb = 0;
        if (!burst) begin
            if (ra && rb) begin ga = last_b; gb = !last_b; end
            else begin ga = ra; gb = rb; end
        end
        check("a_wait", a_waitrequest, ra && !ga);
        check("b_wait", b_waitrequest, rb && !gb);
        check("cs", mem_chipselect, burst || ga || gb);
        if (burst) begin
            check("burst_addr", mem_address, m_baddr);
            check("burst_be", mem_byteenable, m_bbe);
            check("burst_wr", mem_write, 0);
            nvb = 1; ndb = shadow[m_baddr];
            m_baddr = m_baddr + 14'd1;
            left--;
        end else if (ga) begin
            check("a_addr", mem_address, a_address);
            check("a_wr", mem_write, a_write);
            if (a_write) begin
                check("a_wdata", mem_writedata, a_writedata);
                check("a_be", mem_byteenable, a_byteenable);
                shadow_write(a_address, a_byteenable, a_writedata);
            end else begin
                nva = 1; nda = shadow[a_address];
            end
            last_b = 0;
        end else if (gb) begin
            check("b_addr", mem_address, b_address);
            check("b_wr", mem_write, b_write);
            check("b_be", mem_byteenable, b_byteenable);
            if (b_write) begin
                check("b_wdata", mem_writedata, b_writedata);
                shadow_write(b_address, b_byteenable, b_writedata);
            end else begin
                nvb = 1; ndb = shadow[b_address];
                k = (b_burstcount == 0) ? 1 : int'(b_burstcount);
                left = k - 1;
                m_baddr = b_address + 14'd1;
                m_bbe = b_byteenable;
            end
            last_b = 1;
        end
        a_acc = ga; b_acc = gb;
        va = nva; vb = nvb; da = nda; db = ndb;
        @(negedge clk);
    endtask

    task automatic idle();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    endtask

    function automatic logic [13:0] rnd_addr();
        logic [13:0] base;
        base = ($urandom_range(0, 1) == 1) ? 14'h3FE0 : 14'h0000;
        return base | 14'($urandom_range(0, 31));
    endfunction

    bit a_pend, b_pend;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i] = '0; shadow[i] = '0;
        end
        q = '0;
        reset_n = 0;
        idle();
        a_address = '0; b_address = '0; a_byteenable = 4'hF;
        b_byteenable = 4'hF; a_writedata = '0; b_writedata = '0;
        b_burstcount = 5'd1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_rdv", a_readdatavalid, 0);
        check("rst_b_rdv", b_readdatavalid, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_clken", mem_clken, 1);
        @(negedge clk);
        reset_n = 1;
        repeat (2) step();

        a_write = 1; a_address = 14'h0010; a_byteenable = 4'hF;
        a_writedata = 32'hDEADBEEF;
        step();
        a_write = 0; a_read = 1;
        step();
        idle();
        #1;
        check("dead_rdv", a_readdatavalid, 1);
        check("dead_data", a_readdata, 32'hDEADBEEF);
        check("dead_brdv", b_readdatavalid, 0);
        step();
        step();

        a_read = 1; a_address = 14'h0010;
        b_read = 1; b_address = 14'h0011; b_burstcount = 5'd1;
        repeat (8) step();
        idle();
        repeat (2) step();

        a_read = 1; a_address = 14'h0003;
        b_read = 1; b_address = 14'h3FFE; b_burstcount = 5'd4;
        b_acc = 0;
        for (int i = 0; i < 4 && !b_acc; i++) step();
        if (!b_acc) check("burst4_acc", 0, 1);
        b_read = 0;
        repeat (6) step();
        idle();
        repeat (2) step();

        b_read = 1; b_address = 14'h0020; b_burstcount = 5'd0;
        b_acc = 0;
        for (int i = 0; i < 4 && !b_acc; i++) step();
        if (!b_acc) check("burst0_acc", 0, 1);
        idle();
        repeat (3) step();

        b_read = 1; b_address = 14'h0100; b_burstcount = 5'd8;
        b_acc = 0;
        for (int i = 0; i < 4 && !b_acc; i++) step();
        if (!b_acc) check("burst8_acc", 0, 1);
        idle();
        step();
        reset_n = 0;
        #1;
        check("midrst_a_rdv", a_readdatavalid, 0);
        check("midrst_b_rdv", b_readdatavalid, 0);
        check("midrst_cs", mem_chipselect, 0);
        @(negedge clk);
        reset_n = 1;
        model_reset();
        repeat (3) step();
        a_read = 1; a_address = 14'h0010;
        step();
        idle();
        step();
        step();

        a_pend = 0; b_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!a_pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    a_pend = 1;
                    a_write = ($urandom_range(0, 2) == 0);
                    a_read = !a_write || ($urandom_range(0, 7) == 0);
                    a_address = rnd_addr();
                    a_byteenable = 4'($urandom);
                    a_writedata = $urandom;
                end else begin
                    a_read = 0; a_write = 0;
                end
            end
            if (!b_pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    b_pend = 1;
                    b_write = ($urandom_range(0, 3) == 0);
                    b_read = !b_write;
                    b_address = rnd_addr();
                    b_byteenable = 4'($urandom);
                    b_writedata = $urandom;
                    b_burstcount = 5'($urandom_range(0, 16));
                end else begin
                    b_read = 0; b_write = 0;
                end
            end
            step();
            if (a_acc) a_pend = 0;
            if (b_acc) b_pend = 0;
        end
        idle();
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
